// File: rtl/bus_hold_arbiter_if.sv
// rtl/bus_hold_arbiter_if.sv - HOLD/HOLDA arbitration bus between the requesters, the CPU and bus_hold_arbiter.
interface bus_hold_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            hold;
    logic            holda;
    logic            bus_owned;
    logic            hlda_err;
    logic            err_clr;

    // master: requesters plus the CPU HOLDA side; slave: the arbiter
    modport master (
        output req, holda, err_clr,
        input  gnt, hold, bus_owned, hlda_err
    );

    modport slave (
        input  req, holda, err_clr,
        output gnt, hold, bus_owned, hlda_err
    );
endinterface

// File: rtl/bus_hold_arbiter.sv
// rtl/bus_hold_arbiter.sv - 386SX HOLD/HOLDA round-robin arbiter for NREQ secondary bus masters.
// Optional grant tenure limit with forced revoke: HOLD_TENURE_LIMIT_EN.
module bus_hold_arbiter #(
    parameter int NREQ         = 2,
    parameter int HLDA_TIMEOUT = 1023,
    parameter int TENURE       = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_hold_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(HLDA_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HLDA = 3'd1;
    localparam logic [2:0] S_GRANT     = 3'd2;
    localparam logic [2:0] S_HANDOFF   = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    if (NREQ < 1 || NREQ > 8 || HLDA_TIMEOUT < 1 || TENURE < 1) begin : g_bad_params
        $error("bus_hold_arbiter: parameter out of range");
    end

    logic [2:0]      state, state_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic            hold_q, hold_n;
    logic            owned_q;
    logic            err_q, err_n, err_set;
    logic [PW-1:0]   rr_ptr, rr_n;
    logic [CW-1:0]   to_cnt, to_cnt_n;

`ifdef HOLD_TENURE_LIMIT_EN
    localparam int TW = $clog2(TENURE + 1);
    logic [TW-1:0]   ten_cnt, ten_cnt_n;
`endif

    logic            any_req, owner_req, others_req, win_found;
    logic [PW-1:0]   winner;
    logic [NREQ-1:0] win_onehot;

    assign any_req    = |bus.req;
    assign owner_req  = |(bus.req & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);

    // Round-robin search starts one past the last winner
    always_comb begin
        int            j;
        logic [PW-1:0] idx;
        win_found  = 1'b0;
        winner     = '0;
        win_onehot = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = PW'(j);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
        win_onehot[winner] = 1'b1;
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt_q;
        hold_n   = hold_q;
        rr_n     = rr_ptr;
        to_cnt_n = to_cnt;
        err_set  = 1'b0;
`ifdef HOLD_TENURE_LIMIT_EN
        ten_cnt_n = ten_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (any_req && !bus.holda) begin
                    hold_n   = 1'b1;
                    to_cnt_n = '0;
                    state_n  = S_WAIT_HLDA;
                end
            end
            S_WAIT_HLDA: begin
                if (bus.holda) begin
                    if (any_req) begin
                        gnt_n   = win_onehot;
                        rr_n    = winner;
                        state_n = S_GRANT;
`ifdef HOLD_TENURE_LIMIT_EN
                        ten_cnt_n = '0;
`endif
                    end else begin
                        hold_n  = 1'b0;
                        state_n = S_RELEASE;
                    end
                end else if (to_cnt != CW'(HLDA_TIMEOUT)) begin
                    // HOLD is never withdrawn here; the timeout only flags the CPU
                    to_cnt_n = to_cnt + 1'b1;
                    if (to_cnt == CW'(HLDA_TIMEOUT - 1)) err_set = 1'b1;
                end
            end
            S_GRANT: begin
                if (!bus.holda) begin
                    gnt_n   = '0;
                    hold_n  = 1'b0;
                    err_set = 1'b1;
                    state_n = S_RELEASE;
                end else if (!owner_req) begin
                    gnt_n = '0;
                    if (others_req) begin
                        state_n = S_HANDOFF;
                    end else begin
                        hold_n  = 1'b0;
                        state_n = S_RELEASE;
                    end
                end
`ifdef HOLD_TENURE_LIMIT_EN
                else if (ten_cnt == TW'(TENURE - 1)) begin
                    // Saturate while alone; revoke as soon as someone else asks
                    if (others_req) begin
                        gnt_n   = '0;
                        state_n = S_HANDOFF;
                    end
                end else begin
                    ten_cnt_n = ten_cnt + 1'b1;
                end
`endif
            end
            S_HANDOFF: begin
                if (!bus.holda) begin
                    hold_n  = 1'b0;
                    err_set = 1'b1;
                    state_n = S_RELEASE;
                end else if (any_req) begin
                    gnt_n   = win_onehot;
                    rr_n    = winner;
                    state_n = S_GRANT;
`ifdef HOLD_TENURE_LIMIT_EN
                    ten_cnt_n = '0;
`endif
                end else begin
                    hold_n  = 1'b0;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                hold_n = 1'b0;
                if (!bus.holda) state_n = S_IDLE;
            end
            default: begin
                gnt_n   = '0;
                hold_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
        err_n = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            owned_q <= 1'b0;
            err_q   <= 1'b0;
            rr_ptr  <= '0;
            to_cnt  <= '0;
`ifdef HOLD_TENURE_LIMIT_EN
            ten_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            gnt_q   <= gnt_n;
            hold_q  <= hold_n;
            owned_q <= |gnt_n;
            err_q   <= err_n;
            rr_ptr  <= rr_n;
            to_cnt  <= to_cnt_n;
`ifdef HOLD_TENURE_LIMIT_EN
            ten_cnt <= ten_cnt_n;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.hold      = hold_q;
    assign bus.bus_owned = owned_q;
    assign bus.hlda_err  = err_q;
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// tb/tb_bus_hold_arbiter.sv - Directed vector bench for bus_hold_arbiter.
module tb_bus_hold_arbiter;
    localparam int NREQ = 2;
    localparam int TO   = 1023;
    localparam int TEN  = 8;
    localparam int NV   = 26;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_hold_arbiter_if #(.NREQ(NREQ)) bus ();

    bus_hold_arbiter #(
        .NREQ(NREQ),
        .HLDA_TIMEOUT(TO),
        .TENURE(TEN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [1:0] req;
        logic       holda;
        logic       err_clr;
        logic [1:0] gnt;
        logic       hold;
        logic       owned;
        logic       err;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;
    int early;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic h, input logic c);
        bus.req     = r;
        bus.holda   = h;
        bus.err_clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_gnt;
        drive(2'b00, 1'b0, 1'b0);

        //         req    holda err_clr gnt  hold owned err
        vecs[0]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", 32'(bus.gnt), 32'd0);
        check("reset hold", 32'(bus.hold), 32'd0);
        check("reset bus_owned", 32'(bus.bus_owned), 32'd0);
        check("reset hlda_err", 32'(bus.hlda_err), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].holda, vecs[i].err_clr);
            step();
            check($sformatf("v%0d gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d hold", i), 32'(bus.hold), 32'(vecs[i].hold));
            check($sformatf("v%0d bus_owned", i), 32'(bus.bus_owned), 32'(vecs[i].owned));
            check($sformatf("v%0d hlda_err", i), 32'(bus.hlda_err), 32'(vecs[i].err));
        end

        // HOLDA timeout, err_clr, then late HOLDA still grants
        drive(2'b01, 1'b0, 1'b0);
        step();
        check("to hold rise", 32'(bus.hold), 32'd1);
        early = 0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (bus.hlda_err !== 1'b0) early++;
        end
        check("to no early err", 32'(early), 32'd0);
        step();
        check("to err at 1023", 32'(bus.hlda_err), 32'd1);
        check("to hold kept", 32'(bus.hold), 32'd1);
        repeat (3) step();
        check("to err sticky", 32'(bus.hlda_err), 32'd1);
        drive(2'b01, 1'b0, 1'b1);
        step();
        check("to err_clr", 32'(bus.hlda_err), 32'd0);
        drive(2'b01, 1'b0, 1'b0);
        step();
        check("to err stays clear", 32'(bus.hlda_err), 32'd0);
        check("to still waiting", 32'(bus.hold), 32'd1);
        drive(2'b01, 1'b1, 1'b0);
        step();
        check("to late grant", 32'(bus.gnt), 32'h1);
        drive(2'b00, 1'b1, 1'b0);
        step();
        check("to release hold", 32'(bus.hold), 32'd0);
        drive(2'b00, 1'b0, 1'b0);
        step();

        // Two masters held requesting: tenure alternation or indefinite grant
        drive(2'b11, 1'b0, 1'b0);
        step();
        drive(2'b11, 1'b1, 1'b0);
        step();
        check("ten first gnt", 32'(bus.gnt), 32'h2);
        for (int n = 1; n <= 30; n++) begin
            step();
`ifdef HOLD_TENURE_LIMIT_EN
            if ((n % (TEN + 1)) == TEN) exp_gnt = 2'b00;
            else exp_gnt = ((n / (TEN + 1)) % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b10;
`endif
            check($sformatf("ten n%0d gnt", n), 32'(bus.gnt), 32'(exp_gnt));
            check($sformatf("ten n%0d hold", n), 32'(bus.hold), 32'd1);
        end

        // Asynchronous reset in the middle of a grant
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst gnt", 32'(bus.gnt), 32'd0);
        check("arst hold", 32'(bus.hold), 32'd0);
        check("arst bus_owned", 32'(bus.bus_owned), 32'd0);
        drive(2'b00, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        check("arst idle hold", 32'(bus.hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
